// File: rtl/topk_merge_acc.sv
// Streaming top-K accumulator: merges each sorted input vector into a held
// descending top-K list and reports the list (plus beat count) at frame end.
module topk_merge_acc #(
  parameter int DATAWIDTH  = 8,
  parameter int DATALENGTH = 8,
  parameter int K          = 8,
  parameter int CNTWIDTH   = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  valid_i,
  input  logic                                  last_i,
  output logic                                  ready_o,
  input  logic [DATALENGTH-1:0][DATAWIDTH-1:0]  x_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [K-1:0][DATAWIDTH-1:0]           y_o,
  output logic [CNTWIDTH-1:0]                   cnt_o
);

  localparam int LOG2K = $clog2(K);

  generate
    if (K != DATALENGTH) begin : g_bad_k
      $error("topk_merge_acc: K must equal DATALENGTH");
    end
    if ((DATALENGTH < 2) || ((1 << LOG2K) != DATALENGTH)) begin : g_bad_len
      $error("topk_merge_acc: DATALENGTH must be a power of 2 and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                        state_q, state_d;
  logic [K-1:0][DATAWIDTH-1:0]   held_q, held_d;
  logic [K-1:0][DATAWIDTH-1:0]   y_q, y_d;
  logic [CNTWIDTH-1:0]           cnt_q, cnt_d;
  logic [CNTWIDTH-1:0]           cnt_out_q, cnt_out_d;
  logic [CNTWIDTH-1:0]           cnt_inc;
  logic [K-1:0][DATAWIDTH-1:0]   merged;
  logic                          accept;

  // Stage 0 is the reverse-max (bitonic, holds top-K of 2K); stages 1..LOG2K
  // are half-cleaners with the larger value moving to the lower index.
  logic [DATAWIDTH-1:0] stg [LOG2K+1][K];

  genvar gi, gs;
  generate
    for (gi = 0; gi < K; gi++) begin : g_rmax
      assign stg[0][gi] = (held_q[gi] > x_i[K-1-gi]) ? held_q[gi] : x_i[K-1-gi];
    end
    for (gs = 0; gs < LOG2K; gs++) begin : g_stage
      localparam int D = K >> (gs + 1);
      for (gi = 0; gi < K; gi++) begin : g_ce
        if ((gi & D) == 0) begin : g_hi
          assign stg[gs+1][gi] = (stg[gs][gi] >= stg[gs][gi+D]) ? stg[gs][gi] : stg[gs][gi+D];
        end else begin : g_lo
          assign stg[gs+1][gi] = (stg[gs][gi-D] >= stg[gs][gi]) ? stg[gs][gi] : stg[gs][gi-D];
        end
      end
    end
    for (gi = 0; gi < K; gi++) begin : g_out
      assign merged[gi] = stg[LOG2K][gi];
    end
  endgenerate

  assign ready_o     = (state_q != DONE);
  assign accept      = valid_i && ready_o;
  assign out_valid_o = (state_q == DONE);
  assign y_o         = y_q;
  assign cnt_o       = cnt_out_q;
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    cnt_out_d = cnt_out_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          held_d = merged;
          cnt_d  = (state_q == IDLE) ? CNTWIDTH'(1) : cnt_inc;
          if (last_i) begin
            state_d   = DONE;
            y_d       = merged;
            cnt_out_d = cnt_d;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d   = IDLE;
          held_d    = '0;
          cnt_d     = '0;
          y_d       = '0;
          cnt_out_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      held_q    <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      cnt_out_q <= '0;
    end else begin
      state_q   <= state_d;
      held_q    <= held_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      cnt_out_q <= cnt_out_d;
    end
  end

endmodule

// File: tb/tb_topk_merge_acc.sv
// Bench for topk_merge_acc: directed table, hand-written corner sequences,
// and random frames checked against a sort-and-truncate model.
module tb_topk_merge_acc;
  localparam int DW = 8;
  localparam int DL = 8;
  localparam int KK = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst, valid, last, ready, out_valid, out_ready;
  logic [DL-1:0][DW-1:0] x;
  logic [KK-1:0][DW-1:0] y;
  logic [CW-1:0] cnt;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  topk_merge_acc #(.DATAWIDTH(DW), .DATALENGTH(DL), .K(KK), .CNTWIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .last_i(last), .ready_o(ready),
    .x_i(x), .out_valid_o(out_valid), .out_ready_i(out_ready), .y_o(y), .cnt_o(cnt)
  );

  typedef struct packed {
    logic [1:0]       nb;
    logic [2:0][63:0] beats;
    logic [63:0]      ey;
    logic [15:0]      ecnt;
  } vec_t;

  function automatic logic [63:0] v8(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic beat(input logic [63:0] v, input logic l);
    int t;
    t = 0;
    valid = 1'b1;
    x = v;
    last = l;
    while (!ready && t < 50) begin
      step();
      t++;
    end
    if (!ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: ready stayed %b, expected 1", ready);
    end
    step();
    valid = 1'b0;
    last = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [63:0] ey, input int ecnt);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_cnt"}, 64'(cnt), 64'(ecnt));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_drain_y"}, y, 64'd0);
    chk({tag, "_drain_ready"}, 64'(ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[3];
    logic [63:0] y_hold;
    int q[$];
    int tq[$];
    int nb, lim, tmp;
    logic [63:0] bv, ey;

    tbl[0] = '{nb: 2'd1, beats: {64'd0, 64'd0, v8(9,7,5,4,3,2,1,0)},
               ey: v8(9,7,5,4,3,2,1,0), ecnt: 16'd1};
    tbl[1] = '{nb: 2'd2, beats: {64'd0, v8(7,5,3,3,2,0,0,0), v8(8,6,4,2,1,1,0,0)},
               ey: v8(8,7,6,5,4,3,3,2), ecnt: 16'd2};
    tbl[2] = '{nb: 2'd3, beats: {3{v8(255,255,255,255,255,255,255,255)}},
               ey: v8(255,255,255,255,255,255,255,255), ecnt: 16'd3};

    rst = 1'b1; valid = 1'b0; last = 1'b0; out_ready = 1'b0; x = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y", y, 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);

    for (int t = 0; t < 3; t++) begin
      for (int b = 0; b < int'(tbl[t].nb); b++)
        beat(tbl[t].beats[b], b == int'(tbl[t].nb) - 1);
      check_result($sformatf("tbl%0d", t), tbl[t].ey, int'(tbl[t].ecnt));
      drain($sformatf("tbl%0d", t));
    end

    // Backpressure: DONE held 5 cycles while a new beat waits at the input.
    beat(v8(9,7,5,4,3,2,1,0), 1'b1);
    y_hold = v8(9,7,5,4,3,2,1,0);
    valid = 1'b1; last = 1'b1; x = v8(3,3,1,0,0,0,0,0);
    for (int c = 0; c < 5; c++) begin
      chk("bp_ready", 64'(ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_y", y, y_hold);
      chk("bp_cnt", 64'(cnt), 64'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_exit_valid", 64'(out_valid), 64'd0);
    chk("bp_exit_ready", 64'(ready), 64'd1);
    step();
    valid = 1'b0; last = 1'b0;
    check_result("bp_next", v8(3,3,1,0,0,0,0,0), 1);
    drain("bp_next");

    // Reset mid-frame discards the partial list.
    beat(v8(50,40,30,20,10,5,4,3), 1'b0);
    beat(v8(60,41,31,21,11,6,2,1), 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_y", y, 64'd0);
    chk("mrst_cnt", 64'(cnt), 64'd0);
    chk("mrst_ready", 64'(ready), 64'd1);
    @(negedge clk) rst = 1'b0;
    step();
    beat(v8(1,0,0,0,0,0,0,0), 1'b1);
    check_result("mrst_next", v8(1,0,0,0,0,0,0,0), 1);
    drain("mrst_next");

    // Random frames against a sort-and-truncate model.
    for (int f = 0; f < 1000; f++) begin
      nb = int'($urandom_range(1, 20));
      q.delete();
      for (int b = 0; b < nb; b++) begin
        tq.delete();
        lim = ($urandom_range(0, 1) == 1) ? 255 : 7;
        for (int e = 0; e < DL; e++) tq.push_back(int'($urandom_range(0, lim)));
        tq.rsort();
        for (int e = 0; e < DL; e++) begin
          tmp = tq[e];
          bv[e*8 +: 8] = tmp[7:0];
          q.push_back(tq[e]);
        end
        if ($urandom_range(0, 3) == 0) begin
          valid = 1'b0;
          last = 1'($urandom_range(0, 1));
          x = {$urandom, $urandom};
          step();
          last = 1'b0;
        end
        beat(bv, b == nb - 1);
      end
      q.rsort();
      for (int e = 0; e < KK; e++) begin
        tmp = q[e];
        ey[e*8 +: 8] = tmp[7:0];
      end
      repeat ($urandom_range(0, 2)) step();
      chk($sformatf("rnd%0d_y", f), y, ey);
      chk($sformatf("rnd%0d_cnt", f), 64'(cnt), 64'(nb));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/topk_merge_acc.md
Name: topk_merge_acc

Overview:
- Streaming top-K accumulator that sits directly downstream of the 8-input bitonic sorter.
- Each accepted beat is one sorted DATALENGTH-element vector. The block merges it with a held running top-K list using a bitonic merge (reverse-max plus half-cleaner).
- At frame end it presents the K largest values seen across the frame, sorted descending.
- It is the accumulation stage of the top-k datapath and turns per-vector sort results into a per-frame top-K.

Parameters:
- DATAWIDTH, 8, element width; values are unsigned.
- DATALENGTH, 8, elements per input vector. Must be a power of 2 and at least 2.
- K, 8, size of the held top-K list. Must equal DATALENGTH; elaboration fails otherwise.
- CNTWIDTH, 16, width of the per-frame beat counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  input beat valid.
- last_i  input  1  marks the final beat of a frame; qualified by valid_i.
- ready_o  output  1  block can accept a beat this cycle.
- x_i  input  DATAWIDTH x DATALENGTH  sorted vector, descending; x_i[0] is the maximum.
- out_valid_o  output  1  result available.
- out_ready_i  input  1  downstream accepts the result.
- y_o  output  DATAWIDTH x K  frame top-K, descending; y_o[0] is the maximum.
- cnt_o  output  CNTWIDTH  beats accepted in the reported frame.

Behaviour:
- Reset (async assert, sync release): state IDLE; held list all zeros; beat count 0; ready_o=1; out_valid_o=0; y_o all zeros; cnt_o=0.
- Accept condition: valid_i && ready_o. ready_o=1 in IDLE and ACCUM, 0 in DONE.
- Merge, combinational within one cycle:
  - m[i] = max(held[i], x_i[K-1-i]) for i=0..K-1. The result is bitonic and contains the top-K of the 2K values.
  - log2(K) half-cleaner stages (compare-exchange distance K/2 down to 1, larger value to the lower index) sort m descending.
  - The sorted result is written to the held list on the accept edge.
- FSM:
  - IDLE: on accept, merge, count=1. If last_i, go to DONE; else go to ACCUM.
  - ACCUM: on accept, merge, count=count+1, saturating at 2^CNTWIDTH-1. If last_i, go to DONE. No accept means hold.
  - DONE: out_valid_o=1; y_o=held list; cnt_o=count. Outputs stay stable while out_ready_i=0. When out_ready_i=1, clear the held list to zeros, clear count to 0, and go to IDLE.
- Latency: the result is valid the cycle after the last beat is accepted. A single-beat frame gives out_valid_o on the cycle after its accept.
- No back-to-back overlap: while in DONE, inputs are stalled (ready_o=0). In the cycle DONE exits, ready_o is still 0; the next beat is accepted in IDLE.
- y_o and cnt_o are registered. They are driven only from the held state and are zero outside DONE.
- Ties: duplicate values are kept; the count of each duplicate in y_o matches its multiplicity among the top-K.
- Zeros are the identity fill. For a frame with fewer than K nonzero values, the tail of y_o is 0.
- valid_i && last_i in IDLE is a legal one-beat frame.
- last_i without valid_i is ignored.
- Reset asserted mid-frame discards the partial frame immediately.
- Inputs must be stable while valid_i && !ready_o. Inputs that are not sorted descending give undefined ordering, but the block must not lock up.

Test Plan:
- Single beat, x_i={9,7,5,4,3,2,1,0} with last_i=1 -> next cycle out_valid_o=1, y_o={9,7,5,4,3,2,1,0}, cnt_o=1.
- Two beats {8,6,4,2,1,1,0,0} then {7,5,3,3,2,0,0,0} with last -> y_o={8,7,6,5,4,3,3,2}, cnt_o=2.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> y_o stable, ready_o=0, and a valid_i beat is not consumed. Then out_ready_i=1 -> IDLE, and the next frame starts from a zero list.
- Duplicates: three beats of all-0xFF -> y_o all 0xFF, cnt_o=3.
- Reset asserted mid-frame after 2 beats -> all outputs 0 immediately. A subsequent one-beat frame {1,0,...} reports y_o={1,0,0,0,0,0,0,0}, cnt_o=1.
- Random: 1000 frames of 1-20 beats against a sort-and-truncate model -> y_o and cnt_o match for every frame.
